// File: rtl/axi_rd_responder.sv
// AXI read responder: queues AR requests, returns address-pattern bursts READ_LATENCY+1 cycles after pop.
// Optional macro AXI_RD_RESP_STALL_EN inserts LFSR-driven bubbles before each R beat is offered.
module axi_rd_req_fifo #(
  parameter int WIDTH     = 8,
  parameter int LOG_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_dat,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head,
  output logic [LOG_DEPTH:0]   count
);
  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];
endmodule

module axi_rd_responder #(
  parameter int ADDR_BITS            = 64,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_REQ_DEPTH        = 2,
  parameter int READ_LATENCY         = 4,
  localparam int DATA_BITS           = 8 * (1 << LOG_BLOCK_DATA_BYTES)
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       s_ar_valid,
  input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
  input  logic [ADDR_BITS-1:0]       s_ar_addr,
  input  logic [TID_WIDTH-1:0]       s_ar_id,
  output logic                       s_ar_ready,
  output logic                       s_r_valid,
  output logic                       s_r_last,
  output logic [DATA_BITS-1:0]       s_r_data,
  output logic [TID_WIDTH-1:0]       s_r_id,
  input  logic                       s_r_ready,
  output logic                       busy,
  output logic [LOG_REQ_DEPTH:0]     reqCnt
);
  localparam int CNT_BITS   = LOG_REQ_DEPTH + 1;
  localparam int ENTRY_BITS = ADDR_BITS + BURST_LEN_WIDTH + TID_WIDTH;
  localparam logic [CNT_BITS-1:0]  FULL_CNT   = CNT_BITS'(1 << LOG_REQ_DEPTH);
  localparam logic [7:0]           LAT_INIT   = 8'(READ_LATENCY - 1);
  localparam logic [ADDR_BITS-1:0] BEAT_BYTES = ADDR_BITS'(1 << LOG_BLOCK_DATA_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t                     state, state_nxt;
  logic                       ar_en;
  logic                       push, pop, offer;
  logic [ENTRY_BITS-1:0]      head;
  logic [ADDR_BITS-1:0]       h_addr;
  logic [BURST_LEN_WIDTH-1:0] h_len;
  logic [TID_WIDTH-1:0]       h_id;
  logic [ADDR_BITS-1:0]       cur_addr;
  logic [BURST_LEN_WIDTH-1:0] wrk_len;
  logic [BURST_LEN_WIDTH-1:0] beat_idx;
  logic [TID_WIDTH-1:0]       wrk_id;
  logic [TID_WIDTH-1:0]       r_id;
  logic [7:0]                 lat_cnt;
  logic [DATA_BITS-1:0]       data_pat;

  axi_rd_req_fifo #(.WIDTH(ENTRY_BITS), .LOG_DEPTH(LOG_REQ_DEPTH)) u_req_fifo (
    .clk      (clk),
    .resetN   (resetN),
    .push     (push),
    .push_dat ({s_ar_addr, s_ar_len, s_ar_id}),
    .pop      (pop),
    .head     (head),
    .count    (reqCnt)
  );

  // ar_en keeps AR closed while in reset and opens on the first edge after release
  assign s_ar_ready = ar_en && (reqCnt != FULL_CNT);
  assign push       = s_ar_valid && s_ar_ready;
  assign pop        = (state == IDLE) && (reqCnt != '0);
  assign {h_addr, h_len, h_id} = head;
  assign busy       = (state != IDLE) || (reqCnt != '0);
  assign s_r_id     = r_id;

`ifdef AXI_RD_RESP_STALL_EN
  logic [7:0] lfsr;
  logic       offered;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr    <= 8'hA5;
      offered <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      offered <= s_r_valid && !s_r_ready;
    end
  end

  // a beat already on the bus is never withdrawn
  assign offer = offered || !lfsr[0];
`else
  assign offer = 1'b1;
`endif

  always_comb begin
    data_pat = '0;
    for (int i = 0; i < DATA_BITS; i++) data_pat[i] = cur_addr[i % ADDR_BITS];
  end

  always_comb begin
    state_nxt = state;
    s_r_valid = 1'b0;
    s_r_last  = 1'b0;
    s_r_data  = '0;
    case (state)
      IDLE: if (pop) state_nxt = WAIT;
      WAIT: if (lat_cnt == 8'd0) state_nxt = BEAT;
      BEAT: begin
        s_r_valid = offer;
        s_r_last  = (beat_idx == wrk_len);
        s_r_data  = data_pat;
        if (s_r_valid && s_r_ready && s_r_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      ar_en    <= 1'b0;
      cur_addr <= '0;
      wrk_len  <= '0;
      wrk_id   <= '0;
      beat_idx <= '0;
      lat_cnt  <= '0;
      r_id     <= '0;
    end else begin
      state <= state_nxt;
      ar_en <= 1'b1;
      case (state)
        IDLE: if (pop) begin
          cur_addr <= h_addr;
          wrk_len  <= h_len;
          wrk_id   <= h_id;
          beat_idx <= '0;
          lat_cnt  <= LAT_INIT;
        end
        // s_r_id only changes when a new burst starts its beats
        WAIT: if (lat_cnt != 8'd0) lat_cnt <= lat_cnt - 1'b1;
              else                 r_id    <= wrk_id;
        BEAT: if (s_r_valid && s_r_ready) begin
          cur_addr <= cur_addr + BEAT_BYTES;
          beat_idx <= beat_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rd_responder.sv
// Randomized self-checking bench for axi_rd_responder; expected beats come from a burst-expansion model.
module tb_axi_rd_responder;
  localparam int AB = 64, DB = 512, LW = 8, IW = 8, CW = 3, REP = DB / AB, LAT = 4;

  logic          clk = 1'b0, resetN = 1'b1;
  logic          s_ar_valid = 1'b0, s_r_ready = 1'b0;
  logic [LW-1:0] s_ar_len = '0;
  logic [AB-1:0] s_ar_addr = '0;
  logic [IW-1:0] s_ar_id = '0;
  logic          s_ar_ready, s_r_valid, s_r_last, busy;
  logic [DB-1:0] s_r_data;
  logic [IW-1:0] s_r_id;
  logic [CW-1:0] reqCnt;

  int checks = 0, errors = 0, cyc = 0, valid_seen = 0;

  typedef struct {logic [AB-1:0] addr; logic [LW-1:0] len; logic [IW-1:0] id; int cyc;} ar_t;
  typedef struct {logic [DB-1:0] data; logic [IW-1:0] id; logic last; int cyc;} beat_t;
  ar_t   ar_log[$];
  beat_t rx_log[$];
  beat_t exp_q[$];

  axi_rd_responder #(.ADDR_BITS(AB), .LOG_BLOCK_DATA_BYTES(6), .BURST_LEN_WIDTH(LW),
                     .TID_WIDTH(IW), .LOG_REQ_DEPTH(2), .READ_LATENCY(LAT)) dut (
    .clk(clk), .resetN(resetN),
    .s_ar_valid(s_ar_valid), .s_ar_len(s_ar_len), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_ready(s_ar_ready),
    .s_r_valid(s_r_valid), .s_r_last(s_r_last), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_ready(s_r_ready), .busy(busy), .reqCnt(reqCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // log handshakes mid-cycle; they complete on the following rising edge
  always @(negedge clk) begin
    if (resetN) begin
      if (s_ar_valid && s_ar_ready) ar_log.push_back('{s_ar_addr, s_ar_len, s_ar_id, cyc});
      if (s_r_valid) begin
        valid_seen++;
        if (s_r_ready) rx_log.push_back('{s_r_data, s_r_id, s_r_last, cyc});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [DB-1:0] pattern(input logic [AB-1:0] a);
    return {REP{a}};
  endfunction

  // each accepted AR expands, in acceptance order, into len+1 beats 64 bytes apart
  function automatic void build_expected();
    exp_q.delete();
    foreach (ar_log[i])
      for (int k = 0; k <= int'(ar_log[i].len); k++)
        exp_q.push_back('{pattern(ar_log[i].addr + 64'(k) * 64'd64), ar_log[i].id,
                          (k == int'(ar_log[i].len)), 0});
  endfunction

  task automatic clear_logs();
    ar_log.delete();
    rx_log.delete();
    valid_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_ar(input logic [AB-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] id);
    int n = 0;
    s_ar_valid = 1'b1; s_ar_addr = a; s_ar_len = l; s_ar_id = id;
    @(negedge clk);
    while (!s_ar_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_ar_valid = 1'b0;
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL ar_timeout id=%0d ready stayed %b want 1", id, s_ar_ready);
    end
  endtask

  task automatic wait_beats(input int n, input string name);
    int t = 0;
    while (rx_log.size() < n && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (rx_log.size() < n) begin
      errors++;
      $display("FAIL %s_timeout got %0d beats want %0d", name, rx_log.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int t = 0;
    @(negedge clk);
    while (!s_r_valid && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (!s_r_valid) begin errors++; $display("FAIL wait_valid got %b want 1", s_r_valid); end
  endtask

  task automatic test_reset();
    #1 resetN = 1'b0;
    idle(3);
    checks++;
    if ({s_ar_ready, s_r_valid, s_r_last, busy} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got ar_ready=%b valid=%b last=%b busy=%b want 0", s_ar_ready, s_r_valid, s_r_last, busy); end
    checks++;
    if (reqCnt !== 3'd0 || s_r_id !== 8'd0) begin errors++;
      $display("FAIL reset_cnt_id got reqCnt=%0d id=%0d want 0 0", reqCnt, s_r_id); end
    checks++;
    if (s_r_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", s_r_data[63:0]); end
    resetN = 1'b1;
    idle(1);
    checks++;
    if (s_ar_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b want 1", s_ar_ready); end
  endtask

  task automatic test_single();
    clear_logs();
    s_r_ready = 1'b1;
    issue_ar(64'h1000, 8'd3, 8'd5);
    wait_beats(4, "single");
    idle(2);
    build_expected();
    checks++;
    if (rx_log.size() != exp_q.size()) begin errors++;
      $display("FAIL single_count got %0d want %0d", rx_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].id !== exp_q[i].id || rx_log[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL single_beat%0d got addr=%h id=%0d last=%b want addr=%h id=%0d last=%b", i,
                 rx_log[i].data[63:0], rx_log[i].id, rx_log[i].last, exp_q[i].data[63:0], exp_q[i].id, exp_q[i].last);
      end
    end
    if (rx_log.size() >= 4 && ar_log.size() >= 1) begin
      // accept, pop next cycle, then READ_LATENCY+1 to the first beat
      checks++;
      if (rx_log[0].cyc - ar_log[0].cyc != LAT + 2) begin errors++;
        $display("FAIL single_latency got %0d want %0d", rx_log[0].cyc - ar_log[0].cyc, LAT + 2); end
      checks++;
      if (rx_log[3].cyc - rx_log[0].cyc != 3) begin errors++;
        $display("FAIL single_b2b got span %0d want 3", rx_log[3].cyc - rx_log[0].cyc); end
      checks++;
      if (rx_log[3].data[63:0] !== 64'h10C0) begin errors++;
        $display("FAIL single_last_word got %h want 10c0", rx_log[3].data[63:0]); end
    end
    checks++;
    if (s_r_valid !== 1'b0 || s_r_data !== '0 || s_r_id !== 8'd5 || busy !== 1'b0) begin errors++;
      $display("FAIL single_idle got valid=%b id=%0d busy=%b want 0 5 0", s_r_valid, s_r_id, busy); end
  endtask

  task automatic test_fill();
    clear_logs();
    s_r_ready = 1'b0;
    issue_ar({$urandom(), $urandom()}, 8'd0, 8'h10);
    idle(2);
    for (int i = 1; i <= 4; i++) issue_ar({$urandom(), $urandom()}, LW'($urandom_range(0, 3)), IW'(8'h10 + i));
    checks++;
    if (reqCnt !== 3'd4 || s_ar_ready !== 1'b0) begin errors++;
      $display("FAIL fill_full got reqCnt=%0d ready=%b want 4 0", reqCnt, s_ar_ready); end
    idle(3);
    checks++;
    if (ar_log.size() != 5 || s_ar_ready !== 1'b0) begin errors++;
      $display("FAIL fill_blocked got accepts=%0d ready=%b want 5 0", ar_log.size(), s_ar_ready); end
    s_r_ready = 1'b1;
    issue_ar({$urandom(), $urandom()}, 8'd1, 8'h15);
    if (ar_log.size() == 6) begin
      wait_beats(1, "fill_first");
      checks++;
      if (ar_log[5].cyc - rx_log[0].cyc != 2) begin errors++;
        $display("FAIL fill_fifth_accept got %0d cycles after last beat want 2", ar_log[5].cyc - rx_log[0].cyc); end
    end
    build_expected();
    wait_beats(exp_q.size(), "fill");
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].id !== exp_q[i].id || rx_log[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL fill_beat%0d got addr=%h id=%0d last=%b want addr=%h id=%0d last=%b", i,
                 rx_log[i].data[63:0], rx_log[i].id, rx_log[i].last, exp_q[i].data[63:0], exp_q[i].id, exp_q[i].last);
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [AB-1:0] a;
    logic [DB-1:0] snap_d;
    logic          snap_l;
    logic [IW-1:0] snap_i;
    clear_logs();
    a = {$urandom(), $urandom()};
    s_r_ready = 1'b1;
    issue_ar(a, 8'd3, 8'd7);
    wait_valid();
    @(posedge clk); #1;
    s_r_ready = 1'b0;
    snap_d = s_r_data; snap_l = s_r_last; snap_i = s_r_id;
    checks++;
    if (snap_d !== pattern(a + 64'd64) || snap_l !== 1'b0 || snap_i !== 8'd7) begin errors++;
      $display("FAIL bp_beat2 got addr=%h last=%b id=%0d want addr=%h 0 7", snap_d[63:0], snap_l, snap_i, a + 64'd64); end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (s_r_valid !== 1'b1 || s_r_data !== snap_d || s_r_last !== snap_l || s_r_id !== snap_i) begin errors++;
        $display("FAIL bp_hold%0d got valid=%b addr=%h last=%b id=%0d want 1 %h %b %0d", j, s_r_valid,
                 s_r_data[63:0], s_r_last, s_r_id, snap_d[63:0], snap_l, snap_i); end
    end
    @(posedge clk); #1;
    s_r_ready = 1'b1;
    wait_beats(4, "bp");
    idle(2);
    build_expected();
    checks++;
    if (rx_log.size() != exp_q.size()) begin errors++;
      $display("FAIL bp_count got %0d want %0d", rx_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].last !== exp_q[i].last) begin errors++;
        $display("FAIL bp_beat%0d got addr=%h last=%b want addr=%h last=%b", i,
                 rx_log[i].data[63:0], rx_log[i].last, exp_q[i].data[63:0], exp_q[i].last); end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    s_r_ready = 1'b1;
    issue_ar(64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 8'd9);
    wait_beats(2, "wrap");
    if (rx_log.size() >= 2) begin
      checks++;
      if (rx_log[0].data !== pattern(64'hFFFF_FFFF_FFFF_FFC0) || rx_log[0].last !== 1'b0) begin errors++;
        $display("FAIL wrap_beat1 got addr=%h last=%b want ffffffffffffffc0 0", rx_log[0].data[63:0], rx_log[0].last); end
      checks++;
      if (rx_log[1].data !== '0 || rx_log[1].last !== 1'b1) begin errors++;
        $display("FAIL wrap_beat2 got addr=%h last=%b want 0 1", rx_log[1].data[63:0], rx_log[1].last); end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    s_r_ready = 1'b1;
    issue_ar({$urandom(), $urandom()}, 8'd7, 8'd2);
    issue_ar({$urandom(), $urandom()}, 8'd1, 8'd3);
    issue_ar({$urandom(), $urandom()}, 8'd2, 8'd4);
    wait_valid();
    @(posedge clk); #1;
    checks++;
    if (reqCnt !== 3'd2) begin errors++; $display("FAIL rm_queued got %0d want 2", reqCnt); end
    resetN = 1'b0;
    #1;
    checks++;
    if ({s_ar_ready, s_r_valid, s_r_last, busy} !== 4'b0 || reqCnt !== 3'd0 || s_r_id !== 8'd0 || s_r_data !== '0) begin
      errors++;
      $display("FAIL rm_outputs got ar_ready=%b valid=%b last=%b busy=%b cnt=%0d id=%0d want all 0",
               s_ar_ready, s_r_valid, s_r_last, busy, reqCnt, s_r_id);
    end
    idle(1);
    resetN = 1'b1;
    valid_seen = 0;
    idle(20);
    checks++;
    if (valid_seen != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL rm_quiet got valid cycles=%0d busy=%b want 0 0", valid_seen, busy); end
    clear_logs();
    issue_ar({$urandom(), $urandom()}, 8'd2, 8'd6);
    wait_beats(3, "rm_new");
    idle(2);
    build_expected();
    checks++;
    if (rx_log.size() != 3) begin errors++; $display("FAIL rm_new_count got %0d want 3", rx_log.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].id !== exp_q[i].id || rx_log[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rm_new_beat%0d got addr=%h id=%0d want addr=%h id=%0d", i,
                 rx_log[i].data[63:0], rx_log[i].id, exp_q[i].data[63:0], exp_q[i].id);
      end
    end
  endtask

  task automatic test_ordering();
    int last3 = -1, first1 = -1;
    clear_logs();
    s_r_ready = 1'b1;
    issue_ar({$urandom(), $urandom()}, 8'd3, 8'd3);
    issue_ar({$urandom(), $urandom()}, 8'd2, 8'd1);
    wait_beats(7, "order");
    idle(2);
    foreach (rx_log[i]) begin
      if (rx_log[i].id == 8'd3) last3 = i;
      if (rx_log[i].id == 8'd1 && first1 < 0) first1 = i;
    end
    checks++;
    if (last3 != 3 || first1 != 4) begin errors++;
      $display("FAIL order_ids got last id3 at %0d first id1 at %0d want 3 4", last3, first1); end
    build_expected();
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].id !== exp_q[i].id || rx_log[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL order_beat%0d got addr=%h id=%0d want addr=%h id=%0d", i,
                 rx_log[i].data[63:0], rx_log[i].id, exp_q[i].data[63:0], exp_q[i].id);
      end
    end
  endtask

  task automatic test_random();
    clear_logs();
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          issue_ar({$urandom(), $urandom()}, LW'($urandom_range(0, 7)), IW'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
      end
      begin
        logic          stall_prev = 1'b0;
        logic [DB-1:0] sd = '0;
        logic [IW-1:0] si = '0;
        logic          sl = 1'b0;
        for (int c = 0; c < 600; c++) begin
          @(posedge clk); #1;
          s_r_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (stall_prev) begin
            checks++;
            if (s_r_valid !== 1'b1 || s_r_data !== sd || s_r_id !== si || s_r_last !== sl) begin errors++;
              $display("FAIL rand_hold cyc=%0d got valid=%b addr=%h id=%0d want 1 %h %0d", cyc,
                       s_r_valid, s_r_data[63:0], s_r_id, sd[63:0], si); end
          end
          stall_prev = s_r_valid && !s_r_ready;
          sd = s_r_data; si = s_r_id; sl = s_r_last;
        end
        @(posedge clk); #1;
        s_r_ready = 1'b1;
      end
    join
    build_expected();
    wait_beats(exp_q.size(), "rand");
    idle(2);
    checks++;
    if (rx_log.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_count got %0d want %0d", rx_log.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++) begin
      checks++;
      if (rx_log[i].data !== exp_q[i].data || rx_log[i].id !== exp_q[i].id || rx_log[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rand_beat%0d got addr=%h id=%0d last=%b want addr=%h id=%0d last=%b", i,
                 rx_log[i].data[63:0], rx_log[i].id, rx_log[i].last, exp_q[i].data[63:0], exp_q[i].id, exp_q[i].last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_wrap();
    test_reset_mid_burst();
    test_ordering();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
